// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and load/store (D).
// Data wins ties; a starvation counter bounds how long a pending fetch can be passed over.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  output logic                    i_done_o,
  output logic                    i_stall_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_done_o,
  output logic                    d_stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic {OwnerI, OwnerD} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [CntWidth-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BeWidth-1:0]    mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  grant_i, grant_d;
  logic                  resp_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= OwnerI;
      starve_cnt_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next state and arbitration decision.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req_i && d_req_i) begin
          if (starve_cnt_q == CntMax) grant_i = 1'b1;
          else                        grant_d = 1'b1;
        end else if (i_req_i) begin
          grant_i = 1'b1;
        end else if (d_req_i) begin
          grant_d = 1'b1;
        end
      end
      StIssue: begin
        if (mem_gnt_i) state_d = StWait;
      end
      StWait: begin
        // Only the other side may follow back-to-back; the owner's req still shows the
        // just-completed access.
        if (mem_rvalid_i) begin
          if (owner_q == OwnerI && d_req_i)      grant_d = 1'b1;
          else if (owner_q == OwnerD && i_req_i) grant_i = 1'b1;
          else                                   state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_i || grant_d) state_d = StIssue;
  end

  // Request latching and starvation bookkeeping.
  always_comb begin
    owner_d      = owner_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    starve_cnt_d = starve_cnt_q;
    if (grant_i) begin
      owner_d      = OwnerI;
      mem_we_d     = 1'b0;
      mem_addr_d   = i_addr_i;
      mem_wdata_d  = '0;
      mem_be_d     = '1;
      starve_cnt_d = '0;
    end else if (grant_d) begin
      owner_d     = OwnerD;
      mem_we_d    = d_we_i;
      mem_addr_d  = d_addr_i;
      mem_wdata_d = d_wdata_i;
      mem_be_d    = d_we_i ? d_be_i : '1;
      if (!i_req_i)                    starve_cnt_d = '0;
      else if (starve_cnt_q != CntMax) starve_cnt_d = starve_cnt_q + 1'b1;
    end else if (!i_req_i) begin
      starve_cnt_d = '0;
    end
  end

  // Outputs; done pulses and read data bypass the hold registers in the response cycle.
  always_comb begin
    resp_valid  = (state_q == StWait) && mem_rvalid_i;
    i_done_o    = resp_valid && (owner_q == OwnerI);
    d_done_o    = resp_valid && (owner_q == OwnerD);
    i_rdata_d   = i_done_o ? mem_rdata_i : i_rdata_q;
    d_rdata_d   = (d_done_o && !mem_we_q) ? mem_rdata_i : d_rdata_q;
    i_rdata_o   = i_rdata_d;
    d_rdata_o   = d_rdata_d;
    i_stall_o   = i_req_i && !i_done_o;
    d_stall_o   = d_req_i && !d_done_o;
    mem_req_o   = (state_q == StIssue);
    mem_we_o    = mem_we_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    mem_be_o    = mem_be_q;
  end

endmodule
